// File: rtl/cnn_buf_pkg.sv
// ============================================================================
// Module      : cnn_buf_pkg
// Description : Shared sizing defaults and width helpers for the CNN
//               inter-stage result buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_buf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 14;
  localparam int DEF_ROWS   = 14;

  // Pointer width for a modulo-n index; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold an occupancy of 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int PTR_W = ptr_w(DEF_DEPTH);
  localparam int CNT_W = cnt_w(DEF_DEPTH);

endpackage

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Modulo-MOD up counter with synchronous clear. wrap is a
//               combinational flag: an increment is being applied while the
//               counter sits at MOD-1, so it returns to 0 on this edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
  import cnn_buf_pkg::*;
#(
  parameter int MOD = 14,
  parameter int W   = ptr_w(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic at_last;

  assign at_last = (value == LAST);
  assign wrap    = inc && at_last && !clr;

  // Count up with wrap to zero; clear overrides any increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_last ? '0 : value + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pool_result_buffer.sv
// ============================================================================
// Module      : pool_result_buffer
// Description : DEPTH-entry ring buffer between the pooling stage and the
//               next conv/FC stage. First-word fall-through read port,
//               valid/ready on both sides, occupancy count, and row/frame
//               pulses generated from the read side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_result_buffer
  import cnn_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ROWS   = DEF_ROWS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_ready,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       row_done,
  output logic                       frame_done
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int RW = ptr_w(ROWS);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] row_word;
  logic [RW-1:0] row_idx;

  logic full;
  logic empty;
  logic wr_fire;
  logic rd_fire;
  logic row_wrap;
  logic frame_wrap;
  logic wr_wrap;
  logic rd_wrap;
  logic unused_ptr_wraps;

  // Flags come straight from the registered count, so a read in the same
  // cycle never reopens wr_ready and a write never raises rd_valid early.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];

  // A flush cycle swallows any handshake so nothing is stored or counted.
  assign wr_fire = wr_valid && wr_ready && !flush;
  assign rd_fire = rd_valid && rd_ready && !flush;

  // Pointer wrap flags carry no information beyond the pointer itself.
  assign unused_ptr_wraps = wr_wrap ^ rd_wrap;

  mod_counter #(.MOD(DEPTH), .W(AW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_fire),
    .value (wr_ptr),
    .wrap  (wr_wrap)
  );

  mod_counter #(.MOD(DEPTH), .W(AW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_fire),
    .value (rd_ptr),
    .wrap  (rd_wrap)
  );

  // A row is DEPTH consecutive accepted reads.
  mod_counter #(.MOD(DEPTH), .W(AW)) u_row_word (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_fire),
    .value (row_word),
    .wrap  (row_wrap)
  );

  // Rows advance on each completed row; wrapping here ends the frame.
  mod_counter #(.MOD(ROWS), .W(RW)) u_row_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (row_wrap),
    .value (row_idx),
    .wrap  (frame_wrap)
  );

  // Storage holds no reset; contents behind the read pointer are don't-care.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Occupancy moves only when exactly one side of the buffer fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Row/frame pulses appear the cycle after the closing read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else if (flush) begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_done   <= row_wrap;
      frame_done <= row_wrap && frame_wrap;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool_result_buffer.sv
// ============================================================================
// Module      : tb_pool_result_buffer
// Description : Directed self-checking bench for pool_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_result_buffer;

  localparam int DW = 16;
  localparam int NWORDS = 14 * 14;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [3:0]    count;
  logic          row_done;
  logic          frame_done;

  int vectors;
  int miscompares;

  pool_result_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .count      (count),
    .row_done   (row_done),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    wr_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    step();
  endtask

  task automatic write_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  int nw, nr, rows, frames, frame_row, cyc;
  logic wf, rf;

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    step();

    // ---- 1: reset values, then async reset in the middle of a burst ----
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    write_n(5, 16'h0050);
    chk("burst_count", count, 5);
    wr_valid = 1'b1;
    wr_data  = 16'h0055;
    #1;
    reset = 1'b1;
    #1;
    chk("async_wr_ready", wr_ready, 1);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_count", count, 0);
    wr_valid = 1'b0;
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_row_done", row_done, 0);
    chk("post_rst_count", count, 0);

    // ---- 2: fill with 1..14, first-word latency, overflow drop ----
    wr_valid = 1'b1;
    wr_data  = 16'h0001;
    chk("lat_same_cycle", rd_valid, 0);
    step();
    chk("lat_next_cycle", rd_valid, 1);
    chk("fwft_data", rd_data, 16'h0001);
    write_n(13, 16'h0002);
    chk("fill_count", count, 14);
    chk("fill_wr_ready", wr_ready, 0);
    wr_valid = 1'b1;
    wr_data  = 16'hFFFF;
    step();
    wr_valid = 1'b0;
    chk("overflow_count", count, 14);
    chk("stable_data", rd_data, 16'h0001);
    for (int i = 0; i < 14; i++) begin
      rd_ready = 1'b1;
      chk("fill_data", rd_data, 32'(i + 1));
      step();
    end
    rd_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("row1_done", row_done, 1);
    chk("row1_frame", frame_done, 0);
    step();
    chk("row_done_1cycle", row_done, 0);

    // ---- 3: pointers wrapped after 14/14, new data lands at 0..2 ----
    write_n(3, 16'h00A0);
    chk("wrap_mem0", dut.mem[0], 16'h00A0);
    chk("wrap_mem2", dut.mem[2], 16'h00A2);
    for (int i = 0; i < 3; i++) begin
      rd_ready = 1'b1;
      chk("wrap_data", rd_data, 32'(16'h00A0 + i));
      step();
    end
    rd_ready = 1'b0;
    chk("wrap_empty", rd_valid, 0);

    // ---- 4: simultaneous handshakes at full, mid-level and empty ----
    do_reset();
    write_n(14, 16'h0200);
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 16'h0BAD;
    chk("full_blocks_wr", wr_ready, 0);
    step();
    chk("full_both_count", count, 13);
    wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_count", count, 7);
    wr_valid = 1'b1;
    step();
    chk("mid_both_count", count, 7);
    chk("mid_head_data", rd_data, 16'h0208);
    do_reset();
    rd_ready = 1'b1;
    step();
    chk("empty_read_count", count, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h0321;
    chk("empty_blocks_rd", rd_valid, 0);
    step();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("empty_both_count", count, 1);
    chk("empty_both_data", rd_data, 16'h0321);

    // ---- 5: full frame stream with random consumer gaps ----
    do_reset();
    nw = 0; nr = 0; rows = 0; frames = 0; frame_row = -1; cyc = 0;
    while (nr < NWORDS && cyc < 3000) begin
      wr_valid = (nw < NWORDS);
      wr_data  = DW'(nw + 256);
      rd_ready = ($urandom_range(0, 3) != 0);
      wf = wr_valid && wr_ready;
      rf = rd_valid && rd_ready;
      if (rf) begin
        if (rd_data !== DW'(nr + 256)) chk("stream_data", rd_data, 32'(nr + 256));
        nr++;
      end
      if (wf) nw++;
      step();
      cyc++;
      if (row_done) rows++;
      if (frame_done) begin
        frames++;
        frame_row = rows;
      end
    end
    idle();
    chk("stream_words", nr, NWORDS);
    chk("stream_rows", rows, 14);
    chk("stream_frames", frames, 1);
    chk("frame_on_last_row", frame_row, 14);

    // ---- 6: flush with a pending handshake ----
    write_n(11, 16'h0400);
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    chk("pre_flush_count", count, 9);
    chk("pre_flush_row_word", dut.row_word, 2);
    flush    = 1'b1;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 16'h0777;
    step();
    idle();
    chk("flush_count", count, 0);
    chk("flush_rd_valid", rd_valid, 0);
    chk("flush_row_word", dut.row_word, 0);
    chk("flush_wr_ready", wr_ready, 1);
    chk("flush_row_done", row_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
